// File: rtl/rps_pkg.sv
// rps_pkg: move/result/state encodings, LFSR seed, score width and
// helpers (win evaluation, counter move, LFSR move) for rps_round_ctrl.
package rps_pkg;

  localparam logic [1:0] ROCK     = 2'b00;
  localparam logic [1:0] SCISSOR  = 2'b01;
  localparam logic [1:0] PAPER    = 2'b10;
  localparam logic [1:0] BAD_MOVE = 2'b11;

  localparam logic [1:0] TIE      = 2'b00;
  localparam logic [1:0] USER_WIN = 2'b01;
  localparam logic [1:0] COMP_WIN = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECIDE = 2'b01,
    DRAW   = 2'b10,
    SCORE  = 2'b11
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam int         SCORE_W   = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  function automatic logic beats(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a == ROCK    && b == SCISSOR) ||
           (a == SCISSOR && b == PAPER)   ||
           (a == PAPER   && b == ROCK);
  endfunction

  function automatic logic [1:0] win_eval(
    input logic [1:0] u,
    input logic [1:0] c
  );
    logic [1:0] r;
    unique case (1'b1)
      (u == c):    r = TIE;
      beats(u, c): r = USER_WIN;
      default:     r = COMP_WIN;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] counter_move(
    input logic [1:0] p
  );
    logic [1:0] m;
    case (p)
      ROCK:    m = PAPER;
      SCISSOR: m = ROCK;
      default: m = SCISSOR;
    endcase
    return m;
  endfunction

  // Only the low two bits pick the move; 11 folds onto rock.
  function automatic logic [1:0] lfsr_move(
    input logic [7:0] q
  );
    return (q[1:0] == BAD_MOVE) ? ROCK : q[1:0];
  endfunction

endpackage

// File: rtl/rps_lfsr.sv
// rps_lfsr: free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Ports: CLOCK_50, reset_n (async, low), q[7:0] current state.
module rps_lfsr
  import rps_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  output logic [7:0] q
);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: rock-paper-scissors round FSM, scoring and predictor.
// Ports: CLOCK_50, reset_n, play, user_choice, draw_done in;
// choice_u, choice_c, draw_start, result, score_u, score_c, busy out.
// Define RPS_LEARN_EN to build the learning move predictor.
module rps_round_ctrl
  import rps_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               play,
  input  logic [1:0]         user_choice,
  input  logic               draw_done,
  output logic [1:0]         choice_u,
  output logic [1:0]         choice_c,
  output logic               draw_start,
  output logic [1:0]         result,
  output logic [SCORE_W-1:0] score_u,
  output logic [SCORE_W-1:0] score_c,
  output logic               busy
);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] lfsr_q;
  logic [1:0] pend_u;
  logic [1:0] comp_move;
  logic [1:0] res_nxt;
  logic       start_ok;
  logic       done_ok;

  rps_lfsr u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .q        (lfsr_q)
  );

  assign start_ok = play && (user_choice != BAD_MOVE);
  // draw_done seen alongside draw_start is stale from a prior frame.
  assign done_ok  = draw_done && !draw_start;
  assign busy     = (state != IDLE);
  assign res_nxt  = win_eval(choice_u, choice_c);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_ok) state_nxt = DECIDE;
      DECIDE: state_nxt = DRAW;
      DRAW:   if (done_ok) state_nxt = SCORE;
      SCORE:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      draw_start <= 1'b0;
      pend_u     <= ROCK;
      choice_u   <= ROCK;
      choice_c   <= ROCK;
    end else begin
      state      <= state_nxt;
      draw_start <= (state == DECIDE);
      if (state == IDLE && start_ok) begin
        pend_u <= user_choice;
      end
      if (state == DECIDE) begin
        choice_u <= pend_u;
        choice_c <= comp_move;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      result  <= TIE;
      score_u <= '0;
      score_c <= '0;
    end else if (state == SCORE) begin
      result <= res_nxt;
      if (res_nxt == USER_WIN && score_u != SCORE_MAX) begin
        score_u <= score_u + 1'b1;
      end
      if (res_nxt == COMP_WIN && score_c != SCORE_MAX) begin
        score_c <= score_c + 1'b1;
      end
    end
  end

`ifdef RPS_LEARN_EN
  logic [1:0] last_u;
  logic       last_valid;
  logic [3:0] cnt [3][3];
  logic [3:0] row [3];
  logic [3:0] best;
  logic [1:0] pred;
  logic       row_hit;

  always_comb begin
    row = cnt[2];
    if (last_u == ROCK) begin
      row = cnt[0];
    end else if (last_u == SCISSOR) begin
      row = cnt[1];
    end
    // strict compare keeps the lowest encoding on ties
    pred = ROCK;
    best = row[0];
    if (row[1] > best) begin
      pred = SCISSOR;
      best = row[1];
    end
    if (row[2] > best) begin
      pred = PAPER;
    end
    row_hit = last_valid &&
              ((row[0] | row[1] | row[2]) != 4'd0);
    comp_move = row_hit ? counter_move(pred)
                        : lfsr_move(lfsr_q);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      last_u     <= ROCK;
      last_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          cnt[i][j] <= '0;
        end
      end
    end else if (state == SCORE) begin
      last_u     <= choice_u;
      last_valid <= 1'b1;
      if (last_valid) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            if (last_u == 2'(i) && choice_u == 2'(j) &&
                cnt[i][j] != 4'hF) begin
              cnt[i][j] <= cnt[i][j] + 1'b1;
            end
          end
        end
      end
    end
  end
`else
  assign comp_move = lfsr_move(lfsr_q);
`endif

endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb_rps_round_ctrl: randomized self-checking bench for rps_round_ctrl
// against a move-level model of the game, scores and predictor.
module tb_rps_round_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       play = 1'b0;
  logic [1:0] user_choice = 2'b00;
  logic       draw_done = 1'b0;
  logic [1:0] choice_u;
  logic [1:0] choice_c;
  logic       draw_start;
  logic [1:0] result;
  logic [3:0] score_u;
  logic [3:0] score_c;
  logic       busy;

  int tests = 0;
  int fails = 0;

  rps_round_ctrl dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .play        (play),
    .user_choice (user_choice),
    .draw_done   (draw_done),
    .choice_u    (choice_u),
    .choice_c    (choice_c),
    .draw_start  (draw_start),
    .result      (result),
    .score_u     (score_u),
    .score_c     (score_c),
    .busy        (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // reference LFSR: taps 8,6,5,4 -> bits 7,5,4,3 (mask B8)
  logic [7:0] m_lfsr;
  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  // moves: 0 rock, 1 scissor, 2 paper; m beats (m+1)%3
  int m_su;
  int m_sc;
  int m_res;
  int m_cnt [3][3];
  int m_last;
  bit m_lv;

  task automatic model_reset();
    m_su = 0;
    m_sc = 0;
    m_res = 0;
    m_last = 0;
    m_lv = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m_cnt[i][j] = 0;
  endtask

  function automatic int outcome(int u, int c);
    if (u == c) return 0;
    if (c == (u + 1) % 3) return 1;
    return 2;
  endfunction

  function automatic int predict();
    int lm;
    lm = int'(m_lfsr[1:0]);
    if (lm == 3) lm = 0;
`ifdef RPS_LEARN_EN
    if (m_lv) begin
      int best;
      int p;
      best = 0;
      p = -1;
      for (int k = 0; k < 3; k++) begin
        if (m_cnt[m_last][k] > best) begin
          best = m_cnt[m_last][k];
          p = k;
        end
      end
      if (p >= 0) return (p + 2) % 3;
    end
`endif
    return lm;
  endfunction

  task automatic model_commit(int u, int c);
    m_res = outcome(u, c);
    if (m_res == 1 && m_su < 15) m_su++;
    if (m_res == 2 && m_sc < 15) m_sc++;
    if (m_lv && m_cnt[m_last][u] < 15) m_cnt[m_last][u]++;
    m_last = u;
    m_lv = 1;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drives one full round; returns predicted choice_c and the
  // number of draw_start cycles seen. Optional play poke in DRAW.
  task automatic run_round(
    input int u, input int dly, input bit poke,
    output int ec, output int nds
  );
    nds = 0;
    play = 1'b1;
    user_choice = 2'(u);
    tick();
    play = 1'b0;
    user_choice = 2'($urandom_range(0, 3));
    ec = predict();
    tick();
    nds += int'(draw_start);
    for (int i = 0; i < dly; i++) begin
      if (poke && i == 0) begin
        play = 1'b1;
        user_choice = 2'($urandom_range(0, 2));
      end
      tick();
      play = 1'b0;
      nds += int'(draw_start);
    end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    nds += int'(draw_start);
    tick();
    nds += int'(draw_start);
    model_commit(u, ec);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #3;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    tests++;
    if (draw_start !== 1'b0) begin
      fails++;
      $display("FAIL rst_draw_start got %b want 0", draw_start);
    end
    tests++;
    if (choice_u !== 2'b00 || choice_c !== 2'b00) begin
      fails++;
      $display("FAIL rst_choices got %b/%b want 00/00",
               choice_u, choice_c);
    end
    tests++;
    if (result !== 2'b00) begin
      fails++;
      $display("FAIL rst_result got %b want 00", result);
    end
    tests++;
    if (score_u !== 4'd0 || score_c !== 4'd0) begin
      fails++;
      $display("FAIL rst_scores got %0d/%0d want 0/0",
               score_u, score_c);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle_after got %b want 0", busy);
    end
  endtask

  task automatic test_handshake();
    int ec;
    int n;
    play = 1'b1;
    user_choice = 2'b01;
    tick();
    play = 1'b0;
    user_choice = 2'b11;
    ec = predict();
    tests++;
    if (busy !== 1'b1 || draw_start !== 1'b0) begin
      fails++;
      $display("FAIL hs_decide busy/start got %b/%b want 1/0",
               busy, draw_start);
    end
    tick();
    tests++;
    if (draw_start !== 1'b1) begin
      fails++;
      $display("FAIL hs_start_pulse got %b want 1", draw_start);
    end
    tests++;
    if (choice_u !== 2'b01) begin
      fails++;
      $display("FAIL hs_choice_u got %b want 01", choice_u);
    end
    tests++;
    if (choice_c !== 2'(ec)) begin
      fails++;
      $display("FAIL hs_choice_c got %0d want %0d", choice_c, ec);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n += int'(draw_start);
    end
    tests++;
    if (n != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hs_draw_wait starts %0d busy %b want 0/1",
               n, busy);
    end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    tests++;
    if (busy !== 1'b1 || result !== 2'b00) begin
      fails++;
      $display("FAIL hs_score busy/result got %b/%b want 1/00",
               busy, result);
    end
    tick();
    model_commit(1, ec);
    tests++;
    if (result !== 2'(m_res)) begin
      fails++;
      $display("FAIL hs_result got %0d want %0d", result, m_res);
    end
    tests++;
    if (score_u !== 4'(m_su) || score_c !== 4'(m_sc)) begin
      fails++;
      $display("FAIL hs_scores got %0d/%0d want %0d/%0d",
               score_u, score_c, m_su, m_sc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL hs_busy_end got %b want 0", busy);
    end
  endtask

  task automatic test_ignored();
    int n;
    int ec;
    int nds;
    play = 1'b1;
    user_choice = 2'b11;
    tick();
    play = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(draw_start) + int'(busy);
    end
    tests++;
    if (n != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ign_invalid activity %0d want 0", n);
    end
    run_round(2, 4, 1'b1, ec, nds);
    tests++;
    if (nds != 1) begin
      fails++;
      $display("FAIL ign_draw_play starts %0d want 1", nds);
    end
    tests++;
    if (choice_u !== 2'b10 || choice_c !== 2'(ec)) begin
      fails++;
      $display("FAIL ign_choices got %0d/%0d want 2/%0d",
               choice_u, choice_c, ec);
    end
    tests++;
    if (busy !== 1'b0 || result !== 2'(m_res)) begin
      fails++;
      $display("FAIL ign_end busy/result got %b/%0d want 0/%0d",
               busy, result, m_res);
    end
  endtask

  task automatic test_early_done();
    int ec;
    play = 1'b1;
    user_choice = 2'b00;
    tick();
    play = 1'b0;
    ec = predict();
    draw_done = 1'b1;
    tick();
    tick();
    draw_done = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL early_done_start got busy %b want 1", busy);
    end
    tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL early_done_hold got busy %b want 1", busy);
    end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    tick();
    model_commit(0, ec);
    tests++;
    if (busy !== 1'b0 || result !== 2'(m_res)) begin
      fails++;
      $display("FAIL early_done_end busy/result %b/%0d want 0/%0d",
               busy, result, m_res);
    end
    tests++;
    if (score_u !== 4'(m_su) || score_c !== 4'(m_sc)) begin
      fails++;
      $display("FAIL early_done_scores got %0d/%0d want %0d/%0d",
               score_u, score_c, m_su, m_sc);
    end
  endtask

  task automatic test_random();
    int u;
    int ec;
    int nds;
    for (int r = 0; r < 60; r++) begin
      u = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        play = 1'b1;
        user_choice = 2'b11;
        tick();
        play = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL rnd_invalid r%0d busy %b want 0", r, busy);
        end
      end
      run_round(u, $urandom_range(1, 5),
                $urandom_range(0, 2) == 0, ec, nds);
      tests++;
      if (nds != 1) begin
        fails++;
        $display("FAIL rnd_starts r%0d got %0d want 1", r, nds);
      end
      tests++;
      if (choice_u !== 2'(u) || choice_c !== 2'(ec)) begin
        fails++;
        $display("FAIL rnd_choices r%0d got %0d/%0d want %0d/%0d",
                 r, choice_u, choice_c, u, ec);
      end
      tests++;
      if (choice_c === 2'b11) begin
        fails++;
        $display("FAIL rnd_choice_c_valid r%0d got 11 want 0..2", r);
      end
      tests++;
      if (result !== 2'(m_res)) begin
        fails++;
        $display("FAIL rnd_result r%0d got %0d want %0d",
                 r, result, m_res);
      end
      tests++;
      if (score_u !== 4'(m_su) || score_c !== 4'(m_sc)) begin
        fails++;
        $display("FAIL rnd_scores r%0d got %0d/%0d want %0d/%0d",
                 r, score_u, score_c, m_su, m_sc);
      end
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL rnd_busy r%0d got %b want 0", r, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int ec;
    int nds;
    play = 1'b1;
    user_choice = 2'b10;
    tick();
    play = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    model_reset();
    #2;
    tests++;
    if (busy !== 1'b0 || draw_start !== 1'b0 ||
        result !== 2'b00) begin
      fails++;
      $display("FAIL mid_rst busy/start/result %b/%b/%b want 0/0/00",
               busy, draw_start, result);
    end
    tests++;
    if (choice_u !== 2'b00 || choice_c !== 2'b00 ||
        score_u !== 4'd0 || score_c !== 4'd0) begin
      fails++;
      $display("FAIL mid_rst_regs got %0d %0d %0d %0d want 0 0 0 0",
               choice_u, choice_c, score_u, score_c);
    end
    tick();
    tick();
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      draw_done = (i == 2);
      tick();
      n += int'(draw_start) + int'(busy);
    end
    draw_done = 1'b0;
    tests++;
    if (n != 0 || score_u !== 4'd0 || score_c !== 4'd0) begin
      fails++;
      $display("FAIL mid_rst_release activity %0d scores %0d/%0d",
               n, score_u, score_c);
    end
    run_round(1, 2, 1'b0, ec, nds);
    tests++;
    if (nds != 1 || choice_c !== 2'(ec)) begin
      fails++;
      $display("FAIL mid_rst_next starts %0d choice_c %0d want 1/%0d",
               nds, choice_c, ec);
    end
    tests++;
    if (score_u !== 4'(m_su) || score_c !== 4'(m_sc)) begin
      fails++;
      $display("FAIL mid_rst_scores got %0d/%0d want %0d/%0d",
               score_u, score_c, m_su, m_sc);
    end
  endtask

`ifdef RPS_LEARN_EN
  task automatic test_learning();
    int ec;
    int nds;
    int sc2;
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();
    run_round(0, 2, 1'b0, ec, nds);
    run_round(0, 2, 1'b0, ec, nds);
    sc2 = int'(score_c);
    run_round(0, 2, 1'b0, ec, nds);
    tests++;
    if (choice_c !== 2'b10 || result !== 2'b10) begin
      fails++;
      $display("FAIL learn_r3 choice_c/result %b/%b want 10/10",
               choice_c, result);
    end
    tests++;
    if (int'(score_c) != sc2 + 1) begin
      fails++;
      $display("FAIL learn_r3_score got %0d want %0d",
               score_c, sc2 + 1);
    end
    for (int r = 3; r < 20; r++) begin
      run_round(0, 1, 1'b0, ec, nds);
    end
    tests++;
    if (score_c !== 4'd15) begin
      fails++;
      $display("FAIL learn_sat score_c got %0d want 15", score_c);
    end
    tests++;
    if (score_u !== 4'(m_su) || m_su > 2) begin
      fails++;
      $display("FAIL learn_sat score_u got %0d want %0d",
               score_u, m_su);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_handshake();
    test_ignored();
    test_early_done();
    test_random();
    test_reset_mid();
`ifdef RPS_LEARN_EN
    test_learning();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rps_round_ctrl.md
RPS_ROUND_CTRL -- requirements
Module: rps_round_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are CLOCK_50 and reset_n.
REQ-002 CLOCK_50  input  1  50 MHz system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 play  input  1  one-cycle round request, active high, already debounced and edge-detected upstream.
REQ-005 user_choice  input  2  user move: 00 rock, 01 scissor, 10 paper, 11 invalid.
REQ-006 draw_done  input  1  renderer finished drawing both panels.
REQ-007 choice_u  output  2  registered user move, held stable from DECIDE exit to the next round.
REQ-008 choice_c  output  2  registered computer move, held stable the same way.
REQ-009 draw_start  output  1  one-cycle pulse that starts the renderer.
REQ-010 result  output  2  00 tie, 01 user wins, 10 computer wins, 11 never driven.
REQ-011 score_u, score_c  output  4 each  saturating win counters.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly four states, IDLE, DECIDE, DRAW and SCORE, with these transitions:
- IDLE -> DECIDE when play=1 and user_choice!=11.
- DECIDE -> DRAW after 1 cycle.
- DRAW -> SCORE when draw_done=1.
- SCORE -> IDLE after 1 cycle.
REQ-014 In IDLE, play with user_choice=11 SHALL be ignored; play in any other state SHALL be ignored.
REQ-015 On the DECIDE exit edge, choice_u SHALL load user_choice as sampled on the play edge, and choice_c SHALL load the computed move.
REQ-016 draw_start SHALL be high for exactly the first cycle spent in DRAW, 2 cycles after the play edge.
REQ-017 draw_done SHALL be accepted only in DRAW and not during the draw_start cycle.
REQ-018 Win rules SHALL be: rock beats scissor, scissor beats paper, paper beats rock; equal moves are a tie.
REQ-019 On the SCORE exit edge the block SHALL:
- update result;
- increment the winner's score, saturating at 15;
- leave the scores unchanged on a tie.
REQ-020 A free-running 8-bit Fibonacci LFSR SHALL have taps x^8+x^6+x^5+x^4+1, seed 8'hA5, and advance every cycle.
REQ-021 The LFSR move SHALL be lfsr[1:0], with 11 mapped to 00.
REQ-022 The counter move SHALL be the one that beats the predicted move P:
- P=rock -> paper;
- P=scissor -> rock;
- P=paper -> scissor.

Reset
REQ-023 Reset SHALL force all of the following, regardless of state:
- state IDLE, choice_u=00, choice_c=00, draw_start=0;
- result=00, score_u=score_c=0, busy=0;
- LFSR=8'hA5, all history/count registers cleared.
REQ-024 Reset asserted mid-round SHALL abort the round with no score update, and no draw_start SHALL follow deassertion.

Configuration
REQ-025 The macro RPS_LEARN_EN SHALL select the learning predictor.
REQ-026 With RPS_LEARN_EN defined, the predictor SHALL work as follows:
- It keeps last_u (2 bits), last_valid, and a 3x3 table cnt[prev][next] of 4-bit counters saturating at 15.
- In DECIDE, if last_valid=1 and row cnt[last_u] is nonzero, P is the argmax of that row; ties go to the lowest encoding. choice_c is the counter move to P.
- Otherwise choice_c is the LFSR move.
- On SCORE exit, if last_valid=1, cnt[last_u][choice_u] increments.
- On SCORE exit, last_u<=choice_u and last_valid<=1, whether or not last_valid was already set.
REQ-027 Without RPS_LEARN_EN, choice_c SHALL always be the LFSR move, and the table and history logic SHALL not be synthesised.

Structure
REQ-028 The shared package rps_pkg SHALL hold:
- the move encodings ROCK=2'b00, SCISSOR=2'b01, PAPER=2'b10;
- the result encodings TIE, USER_WIN, COMP_WIN;
- the state encoding;
- the LFSR seed and the score width.
REQ-029 The LFSR SHALL be a sub-module named rps_lfsr, with ports CLOCK_50, reset_n, q[7:0].
REQ-030 Win evaluation and the counter-move mapping SHALL be functions in rps_pkg.

Verification
REQ-031 Handshake: play=1, user_choice=01 in IDLE; draw_done pulsed 10 cycles after draw_start.
- Expected: busy rises next cycle; draw_start pulses at +2; result valid after SCORE; busy back to 0.
REQ-032 Ignored request: play with user_choice=11, and a second play during DRAW.
- Expected: no state change, no extra draw_start.
REQ-033 Learning (RPS_LEARN_EN defined): three rounds with user rock each.
- Expected: round 3 gives choice_c=10 and result=10, with score_c incremented.
REQ-034 Saturation (RPS_LEARN_EN defined): 20 rounds of user rock.
- Expected: score_c=15 at the end; score_u=0 unless one of the LFSR-decided rounds 1-2 gave the user a win.
REQ-035 Reset mid-round: assert reset_n=0 during DRAW.
- Expected: all outputs return to reset values, scores 0, and no draw_start after release until a new play.
REQ-036 No learning (RPS_LEARN_EN undefined):
- choice_c SHALL match a reference LFSR model sampled in DECIDE.
- choice_c SHALL never be 11.
